// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit: FSM states, opcodes,
// ALU operations, immediate formats and datapath mux selects.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXEC_R,
    S_EXEC_I, S_ALUWB, S_BRANCH, S_JALR, S_JAL, S_LUI, S_AUIPC, S_TRAP
  } state_t;

  typedef enum logic [1:0] {OPC_R, OPC_I, OPC_BR, OPC_OTHER} op_class_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2, ALU_OR = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4, ALU_SLT = 3'd5, ALU_SLTU = 3'd6, ALU_PASS_B = 3'd7;

  localparam logic [2:0] IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_J = 3'd3, IMM_U = 3'd4;

  localparam logic [1:0] RES_ALUOUT = 2'd0, RES_DMEM = 2'd1, RES_ALURES = 2'd2;
  localparam logic [1:0] SRCA_PC = 2'd0, SRCA_OLDPC = 2'd1, SRCA_RS1 = 2'd2;
  localparam logic [1:0] SRCB_RS2 = 2'd0, SRCB_IMM = 2'd1, SRCB_FOUR = 2'd2;

  function automatic op_class_t get_op_class(input logic [6:0] op);
    case (op)
      OP_R:      return OPC_R;
      OP_IMM:    return OPC_I;
      OP_BRANCH: return OPC_BR;
      default:   return OPC_OTHER;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// Combinational ALU decoder: funct3/funct7[5] and op class to ALU operation,
// branch-taken polarity and unsupported-encoding flag.
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  op_class_t  op_class,
  output logic [2:0] alu_control,
  output logic       br_on_zero,
  output logic       illegal
);

  always_comb begin
    alu_control = ALU_ADD;
    br_on_zero  = 1'b0;
    illegal     = 1'b0;
    case (op_class)
      OPC_R, OPC_I: begin
        case (funct3)
          3'b000:  alu_control = (op_class == OPC_R && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b011:  alu_control = ALU_SLTU;
          3'b100:  alu_control = ALU_XOR;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: illegal = 1'b1;  // shifts have no ALU support
        endcase
      end
      OPC_BR: begin
        case (funct3)
          3'b000:  begin alu_control = ALU_SUB;  br_on_zero = 1'b1; end
          3'b001:  alu_control = ALU_SUB;
          3'b100:  alu_control = ALU_SLT;
          3'b101:  begin alu_control = ALU_SLT;  br_on_zero = 1'b1; end
          3'b110:  alu_control = ALU_SLTU;
          3'b111:  begin alu_control = ALU_SLTU; br_on_zero = 1'b1; end
          default: illegal = 1'b1;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32I main control FSM; traps on unsupported encodings.
// Optional perf counters (cycle_count, instret_count) under MULTICYCLE_CTRL_PERF_EN.
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter state_t RESET_STATE = S_FETCH
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op_code,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       Zero,
  output logic       adr_src,
  output logic       mem_write,
  output logic       IR_write,
  output logic       reg_write,
  output logic       PC_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] imm_src,
  output logic [2:0] alu_control,
  output logic       illegal
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [31:0] cycle_count,
  output logic [31:0] instret_count
`endif
);

  state_t     state_q, state_d;
  op_class_t  op_class;
  logic [2:0] dec_alu;
  logic       dec_br_on_zero, dec_illegal, f7_bad;

  assign op_class = get_op_class(op_code);
  assign f7_bad   = (op_class == OPC_R) && ((funct7 & 7'b1011111) != 7'd0);

  alu_decoder u_alu_decoder (
    .funct3      (funct3),
    .funct7_5    (funct7[5]),
    .op_class    (op_class),
    .alu_control (dec_alu),
    .br_on_zero  (dec_br_on_zero),
    .illegal     (dec_illegal)
  );

  always_comb begin
    state_d     = state_q;
    adr_src     = 1'b0;
    mem_write   = 1'b0;
    IR_write    = 1'b0;
    reg_write   = 1'b0;
    PC_write    = 1'b0;
    result_src  = RES_ALUOUT;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_RS2;
    imm_src     = IMM_I;
    alu_control = ALU_ADD;
    illegal     = 1'b0;
    case (state_q)
      S_FETCH: begin
        IR_write = 1'b1; PC_write = 1'b1;
        alu_src_b = SRCB_FOUR; result_src = RES_ALURES;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        // ALU_out latches old_PC + B-immediate as the branch target
        alu_src_a = SRCA_OLDPC; alu_src_b = SRCB_IMM; imm_src = IMM_B;
        case (op_code)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:      state_d = S_EXEC_R;
          OP_IMM:    state_d = S_EXEC_I;
          OP_BRANCH: state_d = S_BRANCH;
          OP_JAL:    state_d = S_JAL;
          OP_JALR:   state_d = S_JALR;
          OP_LUI:    state_d = S_LUI;
          OP_AUIPC:  state_d = S_AUIPC;
          default:   state_d = S_TRAP;
        endcase
        if (dec_illegal || f7_bad) state_d = S_TRAP;
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1; alu_src_b = SRCB_IMM;
        imm_src = (op_code == OP_STORE) ? IMM_S : IMM_I;
        state_d = (op_code == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD:  begin adr_src = 1'b1; state_d = S_MEMWB; end
      S_MEMWB:    begin result_src = RES_DMEM; reg_write = 1'b1; state_d = S_FETCH; end
      S_MEMWRITE: begin adr_src = 1'b1; mem_write = 1'b1; state_d = S_FETCH; end
      S_EXEC_R: begin
        alu_src_a = SRCA_RS1; alu_control = dec_alu; state_d = S_ALUWB;
      end
      S_EXEC_I: begin
        alu_src_a = SRCA_RS1; alu_src_b = SRCB_IMM; alu_control = dec_alu;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin reg_write = 1'b1; state_d = S_FETCH; end
      S_BRANCH: begin
        alu_src_a = SRCA_RS1; alu_control = dec_alu;
        PC_write = (Zero == dec_br_on_zero);
        state_d = S_FETCH;
      end
      S_JALR: begin
        alu_src_a = SRCA_RS1; alu_src_b = SRCB_IMM; state_d = S_JAL;
      end
      S_JAL: begin
        alu_src_a = SRCA_OLDPC; alu_src_b = SRCB_FOUR; PC_write = 1'b1;
        state_d = S_ALUWB;
      end
      S_LUI: begin
        alu_src_b = SRCB_IMM; imm_src = IMM_U; alu_control = ALU_PASS_B;
        state_d = S_ALUWB;
      end
      S_AUIPC: begin
        alu_src_a = SRCA_OLDPC; alu_src_b = SRCB_IMM; imm_src = IMM_U;
        state_d = S_ALUWB;
      end
      S_TRAP:  illegal = 1'b1;
      default: state_d = S_TRAP;
    endcase
    if (!reset) begin
      mem_write = 1'b0; IR_write = 1'b0; reg_write = 1'b0; PC_write = 1'b0;
      illegal   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state_q <= RESET_STATE;
    else        state_q <= state_d;
  end

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] cycle_q, cycle_d, instret_q, instret_d;

  always_comb begin
    cycle_d   = cycle_q + 32'd1;
    instret_d = instret_q + {31'd0, state_d == S_FETCH};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  end

  assign cycle_count   = cycle_q;
  assign instret_count = instret_q;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle control words for each
// instruction class, branch polarity, traps and reset behaviour.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op_code;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       Zero;
  logic       adr_src, mem_write, IR_write, reg_write, PC_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] imm_src, alu_control;
`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] cycle_count, instret_count;
`endif

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .reset(reset), .op_code(op_code), .funct3(funct3), .funct7(funct7),
    .Zero(Zero), .adr_src(adr_src), .mem_write(mem_write), .IR_write(IR_write),
    .reg_write(reg_write), .PC_write(PC_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
    .alu_control(alu_control), .illegal(illegal)
`ifdef MULTICYCLE_CTRL_PERF_EN
    , .cycle_count(cycle_count), .instret_count(instret_count)
`endif
  );

  // {adr, mw, irw, rw, pcw, result_src, src_a, src_b, imm_src, alu, illegal}
  logic [17:0] obs;
  assign obs = {adr_src, mem_write, IR_write, reg_write, PC_write, result_src,
                alu_src_a, alu_src_b, imm_src, alu_control, illegal};

  function automatic logic [17:0] pk(input logic adr, mw, irw, rw, pcw,
                                     input logic [1:0] rs, a, b,
                                     input logic [2:0] imm, alu, input logic ill);
    return {adr, mw, irw, rw, pcw, rs, a, b, imm, alu, ill};
  endfunction

  localparam logic [17:0] C_FETCH  = pk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 2'd0, 2'd2, 3'd0, 3'd0, 1'b0);
  localparam logic [17:0] C_DECODE = pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd1, 3'd2, 3'd0, 1'b0);
  localparam logic [17:0] C_ALUWB  = pk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 1'b0);
  localparam logic [17:0] C_TRAP   = pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 1'b1);

  task automatic set_instr(input logic [31:0] ins);
    op_code = ins[6:0]; funct3 = ins[14:12]; funct7 = ins[31:25];
  endtask

  task automatic test_reset();
    reset = 1'b0; Zero = 1'b0; set_instr(32'h0000_0013);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      n_chk++;
      if ({mem_write, IR_write, reg_write, PC_write, illegal} !== 5'b0) begin
        n_fail++;
        $display("FAIL reset_hold cyc%0d got %b want 00000", i,
                 {mem_write, IR_write, reg_write, PC_write, illegal});
      end
    end
    reset = 1'b1; #1;
    n_chk++;
    if (obs !== C_FETCH) begin
      n_fail++; $display("FAIL reset_release got %h want %h", obs, C_FETCH);
    end
  endtask

  task automatic test_r_type();
    logic [31:0] ins [2] = '{32'h002081B3, 32'h402081B3};
    logic [2:0]  alu [2] = '{3'd0, 3'd1};
    logic [17:0] e [4];
    for (int v = 0; v < 2; v++) begin
      set_instr(ins[v]);
      e = '{C_FETCH, C_DECODE, pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd0, 3'd0, alu[v], 1'b0), C_ALUWB};
      for (int i = 0; i < 4; i++) begin
        if (i > 0) begin @(negedge clk); #1; end
        n_chk++;
        if (obs !== e[i]) begin
          n_fail++; $display("FAIL r_type v%0d cyc%0d got %h want %h", v, i, obs, e[i]);
        end
      end
      @(negedge clk); #1;
    end
  endtask

  task automatic test_op_imm();
    logic [2:0]  f3  [3] = '{3'b111, 3'b010, 3'b100};
    logic [2:0]  alu [3] = '{3'd2, 3'd5, 3'd4};
    logic [17:0] e [4];
    for (int v = 0; v < 3; v++) begin
      op_code = 7'b0010011; funct3 = f3[v]; funct7 = 7'b0100000;
      e = '{C_FETCH, C_DECODE, pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd1, 3'd0, alu[v], 1'b0), C_ALUWB};
      for (int i = 0; i < 4; i++) begin
        if (i > 0) begin @(negedge clk); #1; end
        n_chk++;
        if (obs !== e[i]) begin
          n_fail++; $display("FAIL op_imm v%0d cyc%0d got %h want %h", v, i, obs, e[i]);
        end
      end
      @(negedge clk); #1;
    end
  endtask

  task automatic test_load_store();
    logic [17:0] el [5];
    logic [17:0] es [4];
    set_instr(32'h0080A283);
    el = '{C_FETCH, C_DECODE, pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd1, 3'd0, 3'd0, 1'b0),
           pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 1'b0),
           pk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 2'd0, 2'd0, 3'd0, 3'd0, 1'b0)};
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      n_chk++;
      if (obs !== el[i]) begin
        n_fail++; $display("FAIL load cyc%0d got %h want %h", i, obs, el[i]);
      end
    end
    @(negedge clk); #1;
    set_instr(32'h0020A423);  // sw x2,8(x1)
    es = '{C_FETCH, C_DECODE, pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd1, 3'd1, 3'd0, 1'b0),
           pk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 1'b0)};
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      n_chk++;
      if (obs !== es[i]) begin
        n_fail++; $display("FAIL store cyc%0d got %h want %h", i, obs, es[i]);
      end
    end
    @(negedge clk); #1;
  endtask

  task automatic test_branch();
    logic [2:0] f3  [6] = '{3'b000, 3'b000, 3'b001, 3'b101, 3'b110, 3'b111};
    logic       z   [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [2:0] alu [6] = '{3'd1, 3'd1, 3'd1, 3'd5, 3'd6, 3'd6};
    logic       tk  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [17:0] e [3];
    for (int v = 0; v < 6; v++) begin
      op_code = 7'b1100011; funct3 = f3[v]; funct7 = 7'd0; Zero = z[v];
      e = '{C_FETCH, C_DECODE, pk(1'b0, 1'b0, 1'b0, 1'b0, tk[v], 2'd0, 2'd2, 2'd0, 3'd0, alu[v], 1'b0)};
      for (int i = 0; i < 3; i++) begin
        if (i > 0) begin @(negedge clk); #1; end
        n_chk++;
        if (obs !== e[i]) begin
          n_fail++; $display("FAIL branch v%0d cyc%0d got %h want %h", v, i, obs, e[i]);
        end
      end
      @(negedge clk); #1;
    end
    Zero = 1'b0;
  endtask

  task automatic test_jumps();
    logic [17:0] ej [5];
    logic [17:0] jal_w;
    jal_w = pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd1, 2'd2, 3'd0, 3'd0, 1'b0);
    set_instr(32'h000100E7);
    ej = '{C_FETCH, C_DECODE, pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd1, 3'd0, 3'd0, 1'b0),
           jal_w, C_ALUWB};
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      n_chk++;
      if (obs !== ej[i]) begin
        n_fail++; $display("FAIL jalr cyc%0d got %h want %h", i, obs, ej[i]);
      end
    end
    @(negedge clk); #1;
    set_instr(32'h008000EF);  // jal x1,8
    ej = '{C_FETCH, C_DECODE, jal_w, C_ALUWB, C_FETCH};
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      n_chk++;
      if (obs !== ej[i]) begin
        n_fail++; $display("FAIL jal cyc%0d got %h want %h", i, obs, ej[i]);
      end
    end
    @(negedge clk); #1;
  endtask

  task automatic test_upper();
    logic [31:0] ins [2] = '{32'h123452B7, 32'h12345297};
    logic [17:0] mid [2];
    logic [17:0] e [4];
    mid[0] = pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd1, 3'd4, 3'd7, 1'b0);
    mid[1] = pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd1, 3'd4, 3'd0, 1'b0);
    for (int v = 0; v < 2; v++) begin
      set_instr(ins[v]);
      e = '{C_FETCH, C_DECODE, mid[v], C_ALUWB};
      for (int i = 0; i < 4; i++) begin
        if (i > 0) begin @(negedge clk); #1; end
        n_chk++;
        if (obs !== e[i]) begin
          n_fail++; $display("FAIL upper v%0d cyc%0d got %h want %h", v, i, obs, e[i]);
        end
      end
      @(negedge clk); #1;
    end
  endtask

  task automatic test_trap();
    logic [6:0]  op [4] = '{7'b0010011, 7'h7F, 7'b0110011, 7'b1100011};
    logic [2:0]  f3 [4] = '{3'b001, 3'b000, 3'b000, 3'b010};
    logic [6:0]  f7 [4] = '{7'd0, 7'd0, 7'b0000001, 7'd0};
    logic [17:0] e [12];
    for (int v = 0; v < 4; v++) begin
      op_code = op[v]; funct3 = f3[v]; funct7 = f7[v];
      e[0] = C_FETCH; e[1] = C_DECODE;
      for (int k = 2; k < 12; k++) e[k] = C_TRAP;
      for (int i = 0; i < 12; i++) begin
        if (i > 0) begin @(negedge clk); #1; end
        n_chk++;
        if (obs !== e[i]) begin
          n_fail++; $display("FAIL trap v%0d cyc%0d got %h want %h", v, i, obs, e[i]);
        end
      end
      reset = 1'b0; #1;
      n_chk++;
      if ({mem_write, IR_write, reg_write, PC_write, illegal} !== 5'b0) begin
        n_fail++; $display("FAIL trap_reset v%0d got %b want 00000", v,
                           {mem_write, IR_write, reg_write, PC_write, illegal});
      end
      @(negedge clk); reset = 1'b1; #1;
      n_chk++;
      if (obs !== C_FETCH) begin
        n_fail++; $display("FAIL trap_exit v%0d got %h want %h", v, obs, C_FETCH);
      end
    end
  endtask

  task automatic test_reset_mid();
    set_instr(32'h0020A423);
    repeat (3) @(negedge clk);  // DECODE, MEMADR, MEMWRITE
    reset = 1'b0; #1;
    n_chk++;
    if (obs !== pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 1'b0)) begin
      n_fail++; $display("FAIL reset_mid_memwrite got %h want %h", obs,
                         pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 1'b0));
    end
    @(negedge clk); reset = 1'b1; #1;
    n_chk++;
    if (obs !== C_FETCH) begin
      n_fail++; $display("FAIL reset_mid_fetch got %h want %h", obs, C_FETCH);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_r_type();
    test_op_imm();
    test_load_store();
    test_branch();
    test_jumps();
    test_upper();
    test_trap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
